// File: rtl/seq_timing_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seq_timing_decoder
// Description : Sequence counter with a one-hot timing vector (t), plus a
//               latched opcode with one-hot decode (d) and indirect bit.
//               All outputs are decoded from registers only.
// Ports       :
//   clk        - system clock, rising edge active
//   reset      - synchronous active-high reset
//   sc_clr     - clear sequence counter (end of instruction)
//   sc_inc     - increment sequence counter
//   hlt        - freeze sequence counter (opcode register unaffected)
//   op_load    - capture opcode_in and i_in
//   opcode_in  - opcode field from IR (OP_W bits)
//   i_in       - indirect bit from IR
//   sc_count   - current counter value (CNT_W bits)
//   t          - one-hot of sc_count (2**CNT_W bits)
//   d          - one-hot of latched opcode, zero when op_valid is low
//   i_bit      - latched indirect bit
//   op_valid   - opcode register holds a live opcode
//   sc_wrap    - one-cycle pulse after the counter rolls over from max to 0
// Revision    : 1.0 - initial release
// ============================================================================
module seq_timing_decoder #(
    parameter int CNT_W = 4,
    parameter int OP_W  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sc_clr,
    input  logic                  sc_inc,
    input  logic                  hlt,
    input  logic                  op_load,
    input  logic [OP_W-1:0]       opcode_in,
    input  logic                  i_in,
    output logic [CNT_W-1:0]      sc_count,
    output logic [2**CNT_W-1:0]   t,
    output logic [2**OP_W-1:0]    d,
    output logic                  i_bit,
    output logic                  op_valid,
    output logic                  sc_wrap
);

    localparam int               c_NUM_T  = 2**CNT_W;
    localparam int               c_NUM_D  = 2**OP_W;
    localparam logic [CNT_W-1:0] c_SC_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_sc;
    logic             r_wrap;
    logic [OP_W-1:0]  r_op;
    logic             r_i;
    logic             r_op_valid;

    // Sequence counter. Clear outranks halt so the end-of-instruction clear
    // can never be blocked; a clear from max is not a rollover.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sc   <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (sc_clr) begin
                r_sc <= '0;
            end else if (hlt) begin
                r_sc <= r_sc;
            end else if (sc_inc) begin
                r_sc   <= r_sc + CNT_W'(1);
                r_wrap <= (r_sc == c_SC_MAX);
            end
        end
    end

    // Opcode register. A load wins over a simultaneous clear and is not
    // gated by halt; a clear alone only invalidates, opcode and I hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op       <= '0;
            r_i        <= 1'b0;
            r_op_valid <= 1'b0;
        end else if (op_load) begin
            r_op       <= opcode_in;
            r_i        <= i_in;
            r_op_valid <= 1'b1;
        end else if (sc_clr) begin
            r_op_valid <= 1'b0;
        end
    end

    genvar k;
    generate
        for (k = 0; k < c_NUM_T; k++) begin : g_t_decode
            assign t[k] = (r_sc == CNT_W'(k));
        end
        for (k = 0; k < c_NUM_D; k++) begin : g_d_decode
            assign d[k] = r_op_valid && (r_op == OP_W'(k));
        end
    endgenerate

    assign sc_count = r_sc;
    assign i_bit    = r_i;
    assign op_valid = r_op_valid;
    assign sc_wrap  = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_seq_timing_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_timing_decoder
// Description : Scoreboard bench for seq_timing_decoder. Two instances
//               (CNT_W=4/OP_W=3 and CNT_W=3/OP_W=2) share one stimulus
//               stream; an abstract model pushes expected outputs per cycle
//               and a monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_timing_decoder;

    logic       clk;
    logic       reset, sc_clr, sc_inc, hlt, op_load, i_in;
    logic [2:0] opcode;

    logic [3:0]  sc_a;
    logic [15:0] t_a;
    logic [7:0]  d_a;
    logic        i_a, v_a, w_a;

    logic [2:0]  sc_b;
    logic [7:0]  t_b;
    logic [3:0]  d_b;
    logic        i_b, v_b, w_b;

    seq_timing_decoder #(.CNT_W(4), .OP_W(3)) u_dut_a (
        .clk(clk), .reset(reset), .sc_clr(sc_clr), .sc_inc(sc_inc),
        .hlt(hlt), .op_load(op_load), .opcode_in(opcode), .i_in(i_in),
        .sc_count(sc_a), .t(t_a), .d(d_a), .i_bit(i_a),
        .op_valid(v_a), .sc_wrap(w_a)
    );

    seq_timing_decoder #(.CNT_W(3), .OP_W(2)) u_dut_b (
        .clk(clk), .reset(reset), .sc_clr(sc_clr), .sc_inc(sc_inc),
        .hlt(hlt), .op_load(op_load), .opcode_in(opcode[1:0]), .i_in(i_in),
        .sc_count(sc_b), .t(t_b), .d(d_b), .i_bit(i_b),
        .op_valid(v_b), .sc_wrap(w_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] sc;
        logic [63:0] t;
        logic [63:0] d;
        logic        i;
        logic        v;
        logic        w;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int checks = 0;
    int errors = 0;

    // Abstract model: counter value, opcode, etc. as plain integers
    int m_sc[2], m_op[2], m_i[2], m_v[2], m_w[2];
    int cw[2] = '{4, 3};
    int ow[2] = '{3, 2};

    function automatic exp_t model_step(int c, bit r, bit clr, bit inc, bit h,
                                        bit ld, int opc, bit ii);
        exp_t e;
        int modulus = 1 << cw[c];
        if (r) begin
            m_sc[c] = 0; m_op[c] = 0; m_i[c] = 0; m_v[c] = 0; m_w[c] = 0;
        end else begin
            m_w[c] = 0;
            if (clr) m_sc[c] = 0;
            else if (!h && inc) begin
                m_w[c]  = ((m_sc[c] + 1) == modulus) ? 1 : 0;
                m_sc[c] = (m_sc[c] + 1) % modulus;
            end
            if (ld) begin
                m_op[c] = opc % (1 << ow[c]);
                m_i[c]  = int'(ii);
                m_v[c]  = 1;
            end else if (clr) begin
                m_v[c] = 0;
            end
        end
        e.sc = 64'(m_sc[c]);
        e.t  = 64'(1) << m_sc[c];
        e.d  = (m_v[c] != 0) ? (64'(1) << m_op[c]) : 64'(0);
        e.i  = (m_i[c] != 0);
        e.v  = (m_v[c] != 0);
        e.w  = (m_w[c] != 0);
        return e;
    endfunction

    // Drive one cycle of stimulus shortly after the falling edge and record
    // the state both instances should hold after the next rising edge.
    task automatic step(bit r, bit clr, bit inc, bit h, bit ld, int opc, bit ii);
        @(negedge clk);
        #1;
        reset   = r;
        sc_clr  = clr;
        sc_inc  = inc;
        hlt     = h;
        op_load = ld;
        opcode  = 3'(opc);
        i_in    = ii;
        q_a.push_back(model_step(0, r, clr, inc, h, ld, opc, ii));
        q_b.push_back(model_step(1, r, clr, inc, h, ld, opc, ii));
    endtask

    task automatic compare(string name, exp_t e, logic [63:0] sc, logic [63:0] tv,
                           logic [63:0] dv, logic iv, logic vv, logic wv);
        checks++;
        if (sc !== e.sc || tv !== e.t || dv !== e.d ||
            iv !== e.i || vv !== e.v || wv !== e.w) begin
            errors++;
            $display("FAIL %s @%0t: got sc=%0h t=%0h d=%0h i=%0b v=%0b w=%0b, expected sc=%0h t=%0h d=%0h i=%0b v=%0b w=%0b",
                     name, $time, sc, tv, dv, iv, vv, wv,
                     e.sc, e.t, e.d, e.i, e.v, e.w);
        end
    endtask

    // Monitor: the outputs are live every cycle, so each falling edge
    // with a pending expectation is a comparison point.
    always @(negedge clk) begin
        if (q_a.size() != 0) begin
            exp_t e;
            e = q_a.pop_front();
            compare("cfg4x3", e, 64'(sc_a), 64'(t_a), 64'(d_a), i_a, v_a, w_a);
        end
        if (q_b.size() != 0) begin
            exp_t e;
            e = q_b.pop_front();
            compare("cfg3x2", e, 64'(sc_b), 64'(t_b), 64'(d_b), i_b, v_b, w_b);
        end
    end

    initial begin
        reset = 1'b0; sc_clr = 1'b0; sc_inc = 1'b0; hlt = 1'b0;
        op_load = 1'b0; opcode = 3'd0; i_in = 1'b0;

        // Reset and reset state
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Count to 9 with opcode 5 loaded, then reset mid-instruction
        step(0, 0, 1, 0, 1, 5, 1);
        repeat (8) step(0, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Exhaustive opcode decode with alternating indirect bit
        for (int k = 0; k < 8; k++) begin
            step(0, 0, 0, 0, 1, k, bit'(k & 1));
            step(0, 0, 0, 0, 0, 0, 0);
        end
        for (int k = 0; k < 8; k++) begin
            step(0, 0, 0, 0, 1, int'($urandom_range(7)), bit'($urandom_range(1)));
        end

        // Count through a full wrap from 0 (17 increments)
        step(0, 1, 0, 0, 0, 0, 0);
        repeat (17) step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Clear from max does not pulse wrap
        step(0, 1, 0, 0, 0, 0, 0);
        repeat (15) step(0, 0, 1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Priority: clear beats halt and increment; halt beats increment
        repeat (3) step(0, 0, 1, 0, 0, 0, 0);
        step(0, 1, 1, 1, 0, 0, 0);
        repeat (5) step(0, 0, 1, 0, 0, 0, 0);
        repeat (2) step(0, 0, 1, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1, 2, 1);

        // Load and clear together, then clear alone
        step(0, 1, 0, 0, 1, 6, 1);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(49) == 0),
                 ($urandom_range(7) == 0),
                 ($urandom_range(3) != 0),
                 ($urandom_range(5) == 0),
                 ($urandom_range(4) == 0),
                 int'($urandom_range(7)),
                 bit'($urandom_range(1)));
        end
        step(0, 0, 0, 0, 0, 0, 0);

        repeat (2) @(negedge clk);
        #2;
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending, expected 0/0", q_a.size(), q_b.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
